// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: buffers ALU and
// load results in per-channel FIFOs, drops x0 writes, and reports pending writes to decode.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        RegWrite,
  output logic [4:0]  WriteAddr,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadAddr1,
  input  logic [4:0]  ReadAddr2,
  output logic        pend1,
  output logic        pend2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t       alu_mem [DEPTH];
  wb_entry_t       ld_mem  [DEPTH];
  logic [PW-1:0]   alu_wr_ptr, alu_rd_ptr, ld_wr_ptr, ld_rd_ptr;
  logic [CW-1:0]   alu_cnt, ld_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            alu_push, ld_push, alu_pop, ld_pop, alu_ne, ld_ne;
  wb_entry_t       alu_head, ld_head;

  // Readiness depends only on the registered count, so a full FIFO refuses a
  // push even when it is popped in the same cycle.
  assign alu_ready = rst_n && (alu_cnt < CW'(DEPTH));
  assign ld_ready  = rst_n && (ld_cnt  < CW'(DEPTH));

  // An x0 result completes its handshake but is never enqueued.
  assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign ld_push  = ld_valid  && ld_ready  && (ld_rd  != 5'd0);

  assign alu_ne   = (alu_cnt != '0);
  assign ld_ne    = (ld_cnt  != '0);
  assign alu_head = alu_mem[alu_rd_ptr];
  assign ld_head  = ld_mem[ld_rd_ptr];

  // Load wins contention until the ALU has lost STARVE_LIMIT times in a row.
  assign ld_pop  = ld_ne && (!alu_ne || (starve_cnt < SW'(STARVE_LIMIT)));
  assign alu_pop = alu_ne && !ld_pop;

  // NOTE: storage is not reset; an entry is only visible while the count covers it,
  // so clearing pointers and counts is enough to empty the FIFO.
  always_ff @(posedge clk) begin
    if (alu_push) alu_mem[alu_wr_ptr] <= {alu_rd, alu_data};
    if (ld_push)  ld_mem[ld_wr_ptr]   <= {ld_rd, ld_data};
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_wr_ptr <= '0;
      alu_rd_ptr <= '0;
      alu_cnt    <= '0;
    end else begin
      if (alu_push) alu_wr_ptr <= alu_wr_ptr + 1'b1;
      if (alu_pop)  alu_rd_ptr <= alu_rd_ptr + 1'b1;
      case ({alu_push, alu_pop})
        2'b10:   alu_cnt <= alu_cnt + 1'b1;
        2'b01:   alu_cnt <= alu_cnt - 1'b1;
        default: alu_cnt <= alu_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_wr_ptr <= '0;
      ld_rd_ptr <= '0;
      ld_cnt    <= '0;
    end else begin
      if (ld_push) ld_wr_ptr <= ld_wr_ptr + 1'b1;
      if (ld_pop)  ld_rd_ptr <= ld_rd_ptr + 1'b1;
      case ({ld_push, ld_pop})
        2'b10:   ld_cnt <= ld_cnt + 1'b1;
        2'b01:   ld_cnt <= ld_cnt - 1'b1;
        default: ld_cnt <= ld_cnt;
      endcase
    end
  end

  // Only a load win against a waiting ALU entry counts as starvation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (alu_pop) begin
      starve_cnt <= '0;
    end else if (ld_pop && alu_ne) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= alu_pop || ld_pop;
      if (ld_pop) begin
        {WriteAddr, WriteData} <= ld_head;
      end else if (alu_pop) begin
        {WriteAddr, WriteData} <= alu_head;
      end
    end
  end

  function automatic logic fifo_hit(input logic [4:0]    addr,
                                    input wb_entry_t     mem [DEPTH],
                                    input logic [PW-1:0] head,
                                    input logic [CW-1:0] cnt);
    logic          hit;
    logic [PW-1:0] idx;
    hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((k < int'(cnt)) && (mem[idx].rd == addr)) hit = 1'b1;
    end
    return hit;
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (ReadAddr1 != 5'd0) begin
      pend1 = fifo_hit(ReadAddr1, alu_mem, alu_rd_ptr, alu_cnt) ||
              fifo_hit(ReadAddr1, ld_mem, ld_rd_ptr, ld_cnt) ||
              (RegWrite && (WriteAddr == ReadAddr1));
    end
    if (ReadAddr2 != 5'd0) begin
      pend2 = fifo_hit(ReadAddr2, alu_mem, alu_rd_ptr, alu_cnt) ||
              fifo_hit(ReadAddr2, ld_mem, ld_rd_ptr, ld_cnt) ||
              (RegWrite && (WriteAddr == ReadAddr2));
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, x0 discard, hazard
// flags, load/ALU arbitration order with backpressure, and reset mid-stream.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic [4:0]  ReadAddr1, ReadAddr2;
  logic        pend1, pend2;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rf [32];

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .RegWrite  (RegWrite),
    .WriteAddr (WriteAddr),
    .WriteData (WriteData),
    .ReadAddr1 (ReadAddr1),
    .ReadAddr2 (ReadAddr2),
    .pend1     (pend1),
    .pend2     (pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits at the edge following RegWrite high.
  always @(posedge clk) if (RegWrite) rf[WriteAddr] <= WriteData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  exp_order [16];
    logic [31:0] exp_data;
    int          ai, li, wcount, stalls;
    logic        a_hs, l_hs;

    exp_order = '{5'd1, 5'd2, 5'd3, 5'd9, 5'd4, 5'd5, 5'd6, 5'd10,
                  5'd7, 5'd8, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
    ReadAddr1 = 5'd5; ReadAddr2 = 5'd7;

    // Reset state
    #3;
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_waddr", WriteAddr, 5'd0);
    check("rst_wdata", WriteData, 32'h0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_ld_ready", ld_ready, 1'b0);
    check("rst_pend1", pend1, 1'b0);
    check("rst_pend2", pend2, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rel_alu_ready", alu_ready, 1'b1);
    check("rel_ld_ready", ld_ready, 1'b1);

    // Single ALU write to R5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hAAAA_AAAA; ReadAddr1 = 5'd5;
    #1;
    check("sw_pend1_before", pend1, 1'b0);
    tick();
    alu_valid = 1'b0;
    check("sw_pend1_queued", pend1, 1'b1);
    check("sw_regwrite_lat", RegWrite, 1'b0);
    tick();
    check("sw_regwrite", RegWrite, 1'b1);
    check("sw_waddr", WriteAddr, 5'd5);
    check("sw_wdata", WriteData, 32'hAAAA_AAAA);
    check("sw_pend1_inflight", pend1, 1'b1);
    tick();
    check("sw_regwrite_drop", RegWrite, 1'b0);
    check("sw_waddr_hold", WriteAddr, 5'd5);
    check("sw_pend1_clear", pend1, 1'b0);
    check("sw_rf5", rf[5], 32'hAAAA_AAAA);

    // x0 load is accepted and dropped
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hDEAD_BEEF; ReadAddr1 = 5'd0;
    #1;
    check("x0_ld_ready", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("x0_regwrite", RegWrite, 1'b0);
      check("x0_pend1", pend1, 1'b0);
      tick();
    end

    // Hazard flags for a load to R7
    ReadAddr1 = 5'd8; ReadAddr2 = 5'd7;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_0077;
    #1;
    check("hz_pend2_before", pend2, 1'b0);
    tick();
    ld_valid = 1'b0;
    #1;
    check("hz_pend2_queued", pend2, 1'b1);
    check("hz_pend1_queued", pend1, 1'b0);
    check("hz_regwrite_lat", RegWrite, 1'b0);
    tick();
    check("hz_regwrite", RegWrite, 1'b1);
    check("hz_waddr", WriteAddr, 5'd7);
    check("hz_pend2_inflight", pend2, 1'b1);
    check("hz_pend1_inflight", pend1, 1'b0);
    tick();
    check("hz_regwrite_drop", RegWrite, 1'b0);
    check("hz_pend2_clear", pend2, 1'b0);
    check("hz_pend1_clear", pend1, 1'b0);

    // Both channels streaming: starvation guard order and load backpressure
    ReadAddr1 = 5'd0; ReadAddr2 = 5'd0;
    ai = 9; li = 1; wcount = 0; stalls = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      alu_valid = (ai <= 16);
      alu_rd    = 5'(ai);
      alu_data  = 32'hA000_0000 | 32'(ai);
      ld_valid  = (li <= 8);
      ld_rd     = 5'(li);
      ld_data   = 32'h1000_0000 | 32'(li);
      #1;
      a_hs = alu_valid && alu_ready;
      l_hs = ld_valid && ld_ready;
      if (ld_valid && !ld_ready) stalls++;
      tick();
      if (a_hs) ai++;
      if (l_hs) li++;
      if (RegWrite) begin
        if (wcount < 16) begin
          exp_data = (exp_order[wcount] <= 5'd8) ? (32'h1000_0000 | 32'(exp_order[wcount]))
                                                 : (32'hA000_0000 | 32'(exp_order[wcount]));
          check($sformatf("order_addr_%0d", wcount), WriteAddr, exp_order[wcount]);
          check($sformatf("order_data_%0d", wcount), WriteData, exp_data);
        end
        wcount++;
      end
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check("order_total_writes", wcount, 16);
    check("ld_backpressure_seen", stalls > 0, 1'b1);
    check("rf_r9", rf[9], 32'hA000_0009);
    check("rf_r8", rf[8], 32'h1000_0008);

    // Reset mid-stream with one write in flight and one entry queued
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_0020; ReadAddr1 = 5'd21;
    tick();
    alu_rd = 5'd21; alu_data = 32'h0000_0021;
    tick();
    alu_valid = 1'b0;
    #1;
    check("mid_regwrite_pre", RegWrite, 1'b1);
    check("mid_pend1_pre", pend1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_regwrite", RegWrite, 1'b0);
    check("mid_rst_waddr", WriteAddr, 5'd0);
    check("mid_rst_wdata", WriteData, 32'h0);
    check("mid_rst_alu_ready", alu_ready, 1'b0);
    check("mid_rst_ld_ready", ld_ready, 1'b0);
    check("mid_rst_pend1", pend1, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_alu_ready", alu_ready, 1'b1);
    check("mid_rel_ld_ready", ld_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_stale_write", RegWrite, 1'b0);
      check("mid_no_stale_pend", pend1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
